imem_loader: RTL
================

# imem_loader

Boot-time program loader that fills the CPU's instruction memory from a byte stream and then releases the core. It accepts bytes over a valid/ready handshake, parses a 16-bit big-endian word count, packs each group of four bytes into a big-endian 32-bit instruction, and issues single-cycle writes to the instruction memory write port. While loading, the CPU is held in reset. The loader releases the CPU only after the final write has landed.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2**ADDR_WIDTH words
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- reload  in  1  from RUN/ERROR: restart load sequence
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address of write
- imem_wdata  out  32  instruction word
- cpu_run  out  1  high = CPU out of reset (drive CPU reset from its inverse)
- done  out  1  load completed successfully (== state RUN)
- error  out  1  load aborted (== state ERROR)
- words_loaded  out  16  count of words written this load

## Operation
- Transfer: byte accepted on an edge where in_valid && in_ready.
- in_ready is high in LEN_HI, LEN_LO, DATA and CHECK. It is low in DRAIN, RUN and ERROR.
- States and transitions:
  - LEN_HI → LEN_LO on accept; the byte is the high byte of N.
  - LEN_LO → on accept (low byte of N):
    - N > 2**ADDR_WIDTH: → ERROR.
    - N == 0: → CHECK when checksum is enabled, else → DRAIN.
    - Otherwise: → DATA.
  - DATA: bytes are packed MSB-first. The 4th byte of a word triggers a write to address words_loaded, and words_loaded increments.
    - After word N: → CHECK when checksum is enabled, else → DRAIN.
  - DRAIN: one cycle, then → RUN.
  - RUN and ERROR: hold until reload, then → LEN_HI. On that transition:
    - cpu_run drops.
    - words_loaded, the byte counter and the checksum clear.
- Reset values: state LEN_HI; all outputs 0 (in_ready goes 1 one cycle after reset deasserts, following from state).
- reset asserted mid-load: loader returns to LEN_HI and the partially packed word is discarded. Memory contents already written are not cleared.
- in_valid while in_ready is low is ignored; the byte is not consumed.
- reload outside RUN/ERROR is ignored.
- words_loaded saturates at N; it never wraps.

## Timing
- Word write: 4th byte accepted at edge k → imem_we/addr/wdata registered high for exactly the cycle k..k+1.
- Back-to-back bytes sustain one byte per cycle, i.e. one word every 4 cycles.
- Release latency, no checksum:
  - Final byte accepted at edge k: state DRAIN at k, RUN at k+1, cpu_run high from edge k+1.
  - The CPU therefore sees the last write committed before its first fetch.
- Release latency, with checksum: checksum byte accepted at edge c → DRAIN at c, RUN/cpu_run at c+1.
- Error latency: error high from the edge of the detecting accept.
- done and cpu_run are asserted together and deasserted together.

## Configuration
- LOADER_CHECKSUM_EN defined: the CHECK state exists.
  - After the N data words, one extra byte is expected: the XOR of all data bytes (length bytes excluded; 0x00 when N == 0).
  - Match → DRAIN; mismatch → ERROR.
  - All data words are still written to memory before the compare.
- LOADER_CHECKSUM_EN undefined: CHECK state, XOR accumulator and compare are absent; DATA goes directly to DRAIN.

## Structure
- Package loader_pkg holds:
  - the state enum (LEN_HI, LEN_LO, DATA, CHECK, DRAIN, RUN, ERROR);
  - LEN_WIDTH = 16;
  - BYTES_PER_WORD = 4.
- Sub-module byte_packer holds the 2-bit byte index and the 32-bit shift register, and emits word_valid with the word.
- imem_loader keeps the FSM, address and word counters, and the checksum.

## Test plan
- Stream 00 02 | 20 08 00 05 | 01 09 50 20, back-to-back: writes 0x20080005 at addr 0 and 0x01095020 at addr 1, each one cycle; cpu_run rises 1 cycle after the second write; words_loaded = 2.
- Same stream with in_valid toggled every other cycle: identical writes; in_ready never drops in DATA.
- N = 0x0101 with ADDR_WIDTH = 8 (exceeds 256): error high right after the LEN_LO accept, no imem_we, cpu_run stays 0.
- Checksum macro on, 00 01 | 12 34 56 78 | 08: done. Repeat with final byte 09: error, cpu_run 0, word still written at addr 0.
- Reset asserted after 2 data bytes, then a clean 1-word load: only the new word is written at addr 0, with no stale bytes.
- In RUN, pulse reload with in_valid high: cpu_run drops the next cycle, and the byte is not consumed that cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  localparam int unsigned LEN_WIDTH      = 16;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DRAIN,
    RUN,
    ERROR
  } state_t;

  // A word count larger than the memory depth cannot be loaded.
  function automatic logic len_too_big(input logic [LEN_WIDTH-1:0] n,
                                       input int unsigned aw);
    return {1'b0, n} > ((LEN_WIDTH+1)'(1) << aw);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words and flags each
// completed word with a one-cycle registered strobe.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] idx;

  assign word_last = byte_valid && (idx == 2'(BYTES_PER_WORD - 1));

  // Shift register and byte index; word_valid follows the 4th byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_last;
      if (clear) begin
        idx <= '0;
      end else if (byte_valid) begin
        word <= {word[23:0], byte_data};
        idx  <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit big-endian word count, writes the packed
// words into instruction memory and then releases the CPU.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  state_t               state;
  logic [7:0]           len_hi;
  logic [LEN_WIDTH-1:0] len;
  logic                 accept;
  logic                 pack_valid;
  logic                 pack_clear;
  logic                 word_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign accept     = in_valid && in_ready;
  assign pack_valid = accept && (state == DATA);
  assign pack_clear = reload && ((state == RUN) || (state == ERROR));

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word_last  (word_last),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  // Load sequencer with registered handshake and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= LEN_HI;
      in_ready     <= 1'b0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      imem_addr    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      if (word_last) begin
        imem_addr <= words_loaded[ADDR_WIDTH-1:0];
        if (words_loaded != len) begin
          words_loaded <= words_loaded + 16'd1;
        end
      end
      case (state)
        LEN_HI: begin
          in_ready <= 1'b1;
          if (accept) begin
            len_hi <= in_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len <= {len_hi, in_data};
            if (len_too_big({len_hi, in_data}, ADDR_WIDTH)) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if ({len_hi, in_data} == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= CHECK;
`else
              state    <= DRAIN;
              in_ready <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (word_last && ((words_loaded + 16'd1) == len)) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= CHECK;
`else
              state    <= DRAIN;
              in_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state <= DRAIN;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        DRAIN: begin
          state   <= RUN;
          cpu_run <= 1'b1;
          done    <= 1'b1;
        end
        RUN, ERROR: begin
          if (reload) begin
            state        <= LEN_HI;
            in_ready     <= 1'b1;
            cpu_run      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        default: begin
          state    <= LEN_HI;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
